// File: rtl/datapath_result_checker.sv
// Scoreboards an arithmetic datapath: recomputes each issued op, delays it LAT cycles, compares with Y/co.
// Latency: compare at issue+LAT, counters/snapshot update one edge later; no backpressure, halts at ERR_LIMIT.
module datapath_result_checker #(
    parameter int N         = 16,
    parameter int LAT       = 2,
    parameter int ERR_LIMIT = 8,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  in_A,
    input  logic [N-1:0]  in_B,
    input  logic [2:0]    in_opcode,
    input  logic [N-1:0]  dut_Y,
    input  logic          dut_co,
    output logic [CW-1:0] chk_count,
    output logic [CW-1:0] err_count,
    output logic          err_flag,
    output logic          halted,
    output logic [2:0]    first_opcode,
    output logic [N-1:0]  first_A,
    output logic [N-1:0]  first_B,
    output logic [N-1:0]  first_exp_Y,
    output logic [N-1:0]  first_got_Y
);

    typedef struct packed {
        logic         vld;
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_y;
        logic         exp_co;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FILL, CHECK, HALT} state_t;

    localparam logic [CW-1:0] MAXC      = '1;
    localparam logic [CW-1:0] LIMIT     = CW'(ERR_LIMIT);
    localparam logic [2:0]    FILL_LAST = (LAT >= 2) ? 3'(LAT - 2) : 3'd0;

    state_t       state, state_nxt;
    logic [2:0]   fill_cnt;
    entry_t       iss, cmp;
    logic [N:0]   sum;
    logic [N-1:0] gold_y;
    logic         gold_co;

    // Golden model evaluated on the issue-cycle operands
    always_comb begin
        sum     = '0;
        gold_y  = '0;
        gold_co = 1'b0;
        case (in_opcode)
            3'b000: begin
                sum     = {1'b0, in_A} + {1'b0, in_B};
                gold_y  = sum[N-1:0];
                gold_co = sum[N];
            end
            3'b001: begin
                sum     = {1'b0, in_A} + {1'b0, ~in_B} + (N+1)'(1);
                gold_y  = sum[N-1:0];
                gold_co = sum[N];
            end
            3'b010:  gold_y = in_A & in_B;
            3'b011:  gold_y = in_A | in_B;
            3'b100:  gold_y = in_A ^ in_B;
            3'b101:  gold_y = ~in_A;
            3'b110:  gold_y = in_A << 1;
            default: gold_y = N'($signed(in_A) >>> 1);
        endcase
    end

    always_comb begin
        iss        = '0;
        iss.vld    = in_valid && (state != HALT);
        iss.op     = in_opcode;
        iss.a      = in_A;
        iss.b      = in_B;
        iss.exp_y  = gold_y;
        iss.exp_co = gold_co;
    end

    generate
        if (LAT == 0) begin : g_comb
            assign cmp = iss;
        end else begin : g_pipe
            entry_t pipe [LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= iss;
                    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign cmp = pipe[LAT-1];
        end
    endgenerate

    logic          do_cmp, mismatch, hit_limit;
    logic [CW-1:0] chk_nxt, err_nxt;

    assign do_cmp    = cmp.vld && (state != HALT);
    assign mismatch  = do_cmp && ((dut_Y != cmp.exp_y) || (dut_co != cmp.exp_co));
    assign chk_nxt   = (chk_count == MAXC) ? chk_count : chk_count + 1'b1;
    assign err_nxt   = (err_count == MAXC) ? err_count : err_count + 1'b1;
    assign hit_limit = mismatch && (err_nxt >= LIMIT);
    assign halted    = (state == HALT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (LAT <= 1) ? CHECK : FILL;
            FILL:    if (fill_cnt == FILL_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = CHECK;
            default: state_nxt = HALT;
        endcase
        // Reaching the limit wins even from IDLE/FILL (LAT=0/1 can compare there)
        if (hit_limit) state_nxt = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= (state == FILL) ? fill_cnt + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_count    <= '0;
            err_count    <= '0;
            err_flag     <= 1'b0;
            first_opcode <= '0;
            first_A      <= '0;
            first_B      <= '0;
            first_exp_Y  <= '0;
            first_got_Y  <= '0;
        end else begin
            if (do_cmp) chk_count <= chk_nxt;
            if (mismatch) err_count <= err_nxt;
            if (mismatch && !err_flag) begin
                err_flag     <= 1'b1;
                first_opcode <= cmp.op;
                first_A      <= cmp.a;
                first_B      <= cmp.b;
                first_exp_Y  <= cmp.exp_y;
                first_got_Y  <= dut_Y;
            end
        end
    end

endmodule

// File: tb/tb_datapath_result_checker.sv
// Directed bench: u0 (ERR_LIMIT=8) for function/snapshot/reset, u1 (ERR_LIMIT=2) for halting.
module tb_datapath_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_A = '0, in_B = '0;
    logic [2:0]  in_opcode = '0;
    logic [15:0] dut_Y = '0;
    logic        dut_co = 1'b0;

    logic [15:0] chk0, err0, chk1, err1;
    logic        flag0, flag1, halt0, halt1;
    logic [2:0]  fop0, fop1;
    logic [15:0] fa0, fb0, fe0, fg0, fa1, fb1, fe1, fg1;

    int n_asrt = 0;
    int n_fail = 0;

    // Datapath stand-in: replays the hand-written Y/co two cycles after issue
    logic [15:0] py0 = '0, py1 = '0;
    logic        pc0 = 1'b0, pc1 = 1'b0;

    always #5 clk = ~clk;

    datapath_result_checker #(.N(16), .LAT(2), .ERR_LIMIT(8), .CW(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_A(in_A), .in_B(in_B),
        .in_opcode(in_opcode), .dut_Y(dut_Y), .dut_co(dut_co),
        .chk_count(chk0), .err_count(err0), .err_flag(flag0), .halted(halt0),
        .first_opcode(fop0), .first_A(fa0), .first_B(fb0),
        .first_exp_Y(fe0), .first_got_Y(fg0)
    );

    datapath_result_checker #(.N(16), .LAT(2), .ERR_LIMIT(2), .CW(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_A(in_A), .in_B(in_B),
        .in_opcode(in_opcode), .dut_Y(dut_Y), .dut_co(dut_co),
        .chk_count(chk1), .err_count(err1), .err_flag(flag1), .halted(halt1),
        .first_opcode(fop1), .first_A(fa1), .first_B(fb1),
        .first_exp_Y(fe1), .first_got_Y(fg1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] y, input logic co);
        dut_Y = py1; dut_co = pc1;
        py1 = py0;  pc1 = pc0;
        py0 = y;    pc0 = co;
        in_valid = v; in_opcode = op; in_A = a; in_B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        step(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bubble();
        bubble();
        rst = 1'b0;
        py0 = '0; py1 = '0; pc0 = 1'b0; pc1 = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_chk", 32'(chk0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_flag", 32'(flag0), 0);
        check("rst_halt", 32'(halt0), 0);
        check("rst_first_exp", 32'(fe0), 0);
        check("rst_state", 32'(u0.state), 0);

        // 0x7FFF + 1: checked exactly two cycles after issue
        step(1'b1, 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        bubble();
        check("lat_not_yet", 32'(chk0), 0);
        bubble();
        check("t1_chk", 32'(chk0), 1);
        check("t1_err", 32'(err0), 0);
        check("t1_flag", 32'(flag0), 0);

        // Carry-out cases for add and subtract
        do_reset();
        step(1'b1, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        step(1'b1, 3'b001, 16'h0005, 16'h0003, 16'h0002, 1'b1);
        bubble();
        bubble();
        check("t2_chk", 32'(chk0), 2);
        check("t2_err", 32'(err0), 0);

        // All opcodes on F0F0/0FF0 with a bubble in the middle
        do_reset();
        step(1'b1, 3'b000, 16'hF0F0, 16'h0FF0, 16'h00E0, 1'b1);
        step(1'b1, 3'b001, 16'hF0F0, 16'h0FF0, 16'hE100, 1'b1);
        step(1'b1, 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0);
        step(1'b1, 3'b011, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0);
        bubble();
        step(1'b1, 3'b100, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0);
        step(1'b1, 3'b101, 16'hF0F0, 16'h0FF0, 16'h0F0F, 1'b0);
        step(1'b1, 3'b110, 16'hF0F0, 16'h0FF0, 16'hE1E0, 1'b0);
        step(1'b1, 3'b111, 16'hF0F0, 16'h0FF0, 16'hF878, 1'b0);
        bubble();
        bubble();
        check("t3_chk", 32'(chk0), 8);
        check("t3_err", 32'(err0), 0);

        // Op 3 has Y bit0 flipped (correct 0x12CB), op 5 is also wrong later
        do_reset();
        step(1'b1, 3'b000, 16'h0001, 16'h0002, 16'h0003, 1'b0);
        step(1'b1, 3'b011, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0);
        step(1'b1, 3'b100, 16'h1234, 16'h00FF, 16'h12CA, 1'b0);
        step(1'b1, 3'b010, 16'hAAAA, 16'h0F0F, 16'h0A0A, 1'b0);
        check("t4_err_before", 32'(err0), 0);
        step(1'b1, 3'b101, 16'h0000, 16'h0000, 16'hFFFE, 1'b0);
        check("t4_err_first", 32'(err0), 1);
        check("t4_flag", 32'(flag0), 1);
        bubble();
        bubble();
        check("t4_chk", 32'(chk0), 5);
        check("t4_err_total", 32'(err0), 2);
        check("t4_first_op", 32'(fop0), 32'h4);
        check("t4_first_A", 32'(fa0), 32'h1234);
        check("t4_first_B", 32'(fb0), 32'h00FF);
        check("t4_first_exp", 32'(fe0), 32'h12CB);
        check("t4_first_got", 32'(fg0), 32'h12CA);
        check("t4_halt0", 32'(halt0), 0);

        // u1 halts on its 2nd error (a carry-out error); further ops are ignored
        do_reset();
        step(1'b1, 3'b000, 16'h0001, 16'h0001, 16'h0003, 1'b0);
        step(1'b1, 3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b1);
        step(1'b1, 3'b000, 16'h0001, 16'h0001, 16'h0005, 1'b0);
        check("t5_err_1", 32'(err1), 1);
        check("t5_not_halted", 32'(halt1), 0);
        step(1'b1, 3'b000, 16'h0001, 16'h0001, 16'h0005, 1'b0);
        check("t5_err_2", 32'(err1), 2);
        check("t5_halted", 32'(halt1), 1);
        step(1'b1, 3'b000, 16'h0001, 16'h0001, 16'h0005, 1'b0);
        step(1'b1, 3'b000, 16'h0001, 16'h0001, 16'h0005, 1'b0);
        bubble();
        bubble();
        check("t5_err_frozen", 32'(err1), 2);
        check("t5_chk_frozen", 32'(chk1), 2);
        check("t5_still_halted", 32'(halt1), 1);
        check("t5_first_got", 32'(fg1), 32'h0003);

        // Reset with two ops in flight discards them
        do_reset();
        step(1'b1, 3'b010, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0);
        step(1'b1, 3'b011, 16'h00FF, 16'h0F0F, 16'h0FFF, 1'b0);
        rst = 1'b1;
        bubble();
        rst = 1'b0;
        check("t6_chk_rst", 32'(chk0), 0);
        check("t6_flag_rst", 32'(flag0), 0);
        check("t6_halt_rst", 32'(halt1), 0);
        check("t6_state", 32'(u0.state), 0);
        bubble();
        bubble();
        bubble();
        check("t6_no_stale", 32'(chk0), 0);
        step(1'b1, 3'b110, 16'h4001, 16'h0000, 16'h8002, 1'b0);
        bubble();
        bubble();
        check("t6_reissue_chk", 32'(chk0), 1);
        check("t6_reissue_err", 32'(err0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_result_checker.md
Name: datapath_result_checker

Overview:
- Self-checking receiver placed at the output side of the pipelined arithmetic datapath.
- Captures each issued operation (A, B, opcode) and computes the golden result itself.
- Delays the golden result by the datapath pipeline latency and compares it against the datapath's Y/co.
- Counts checks and mismatches, and freezes a snapshot of the first failing operation.

Parameters:
- N, 16, operand/result width.
- LAT, 2, datapath pipeline latency in clk cycles (0..4). 0 means the datapath is combinational.
- ERR_LIMIT, 8, mismatch count that halts checking.
- CW, 16, width of the check and error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation issued to the datapath this cycle.
- in_A  in  N  signed operand A, as issued.
- in_B  in  N  signed operand B, as issued.
- in_opcode  in  3  opcode, as issued.
- dut_Y  in  N  datapath result.
- dut_co  in  1  datapath carry out.
- chk_count  out  CW  number of comparisons performed.
- err_count  out  CW  number of mismatches.
- err_flag  out  1  sticky; set on the first mismatch.
- halted  out  1  high in the HALT state.
- first_opcode  out  3  opcode of the first mismatch.
- first_A  out  N  operand A of the first mismatch.
- first_B  out  N  operand B of the first mismatch.
- first_exp_Y  out  N  expected Y of the first mismatch.
- first_got_Y  out  N  received Y of the first mismatch.

Behaviour:
- Golden model (N-bit wrap; co=0 for every opcode other than add/sub):
  - 000: Y=A+B, co = carry out of the unsigned sum.
  - 001: Y=A-B computed as A+~B+1, co = carry out of that sum.
  - 010: A&B.
  - 011: A|B.
  - 100: A^B.
  - 101: ~A.
  - 110: A<<1.
  - 111: A>>>1 (arithmetic).
- Golden values are computed on the in_* inputs in the issue cycle.
- Delay line:
  - LAT stages of registers carry {valid, opcode, A, B, exp_Y, exp_co}.
  - An entry issued at cycle t is compared at cycle t+LAT against dut_Y/dut_co sampled at that cycle.
  - LAT=0: the comparison happens in the issue cycle; counters update at the next edge.
- FSM states, IDLE -> FILL -> CHECK -> HALT:
  - IDLE (after reset): moves to FILL on the first in_valid. With LAT=0, moves directly to CHECK.
  - FILL: waits LAT-1 cycles so the first issued entry reaches the compare stage, then moves to CHECK. Compares are suppressed in FILL only when no valid entry is at the compare stage.
  - CHECK: each valid compare-stage entry increments chk_count. A mismatch on Y or on co increments err_count.
  - HALT: entered at the edge where err_count reaches ERR_LIMIT. Counters and snapshot freeze. in_valid is ignored. Only rst leaves HALT.
- Bubbles: in_valid=0 cycles travel down the delay line as invalid entries. A compare-stage entry with valid=0 causes no count change.
- First-error snapshot: written only when err_flag=0 and a mismatch occurs; err_flag is set in the same edge. Later mismatches never overwrite it.
- Saturation: chk_count and err_count saturate at 2^CW-1 and never wrap.
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - All delay-line valid bits are cleared.
  - Reset mid-operation discards in-flight entries: no compare happens for entries issued before the reset.
- Simultaneous events:
  - A mismatch that raises err_count to ERR_LIMIT is counted and snapshotted (if it is the first), then the block enters HALT.
  - rst has priority over all updates.

Test Plan:
- LAT=2, op=000, A=0x7FFF, B=0x0001, correct DUT: after 2 cycles Y=0x8000, co=0 -> chk_count=1, err_count=0, err_flag=0.
- LAT=2: op=000 with A=0xFFFF, B=0x0001, then op=001 with A=5, B=3 -> expected Y=0x0000/co=1, then Y=2/co=1; chk_count=2, no errors.
- Back-to-back issue of all 8 opcodes with A=0xF0F0, B=0x0FF0, including one in_valid=0 bubble -> chk_count=8; opcode 111 gives Y=0xF878.
- Error injection: the DUT model flips dut_Y bit0 on the 3rd of 5 ops -> err_count=1, err_flag=1, first_opcode/A/B of op 3 captured, first_got_Y = first_exp_Y ^ 1. A later error leaves the snapshot unchanged.
- ERR_LIMIT=2 with continuous mismatches -> halted=1 on the 2nd error edge; further in_valid leaves the counters frozen at err_count=2.
- Assert rst while 2 ops are in flight -> all outputs 0 and state IDLE; the in-flight ops never increment chk_count. Re-issuing a single op then gives chk_count=1.
